// File: rtl/bcd_gate_counter_if.sv
// Signal bundle between the gated BCD counter and the frequency-meter datapath:
// raw measured signal and gate in, seven BCD digits plus status out.
interface bcd_gate_counter_if;
  logic       sig_in;
  logic       gate;
  logic [3:0] num0;
  logic [3:0] num1;
  logic [3:0] num2;
  logic [3:0] num3;
  logic [3:0] num4;
  logic [3:0] num5;
  logic [3:0] num6;
  logic       overflow;
  logic       done;

  modport master (
    output sig_in, gate,
    input  num0, num1, num2, num3, num4, num5, num6, overflow, done
  );

  modport slave (
    input  sig_in, gate,
    output num0, num1, num2, num3, num4, num5, num6, overflow, done
  );
endinterface

// File: rtl/bcd_gate_counter.sv
// Gated seven-digit BCD event counter: counts sig_in rising edges while the
// gate is high, freezes the result while it is low, clears on the next gate rise.
module bcd_gate_counter #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  bcd_gate_counter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CLEAR, COUNT, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sig_sync_q, sig_sync_d;
  logic [SYNC_STAGES-1:0] gate_sync_q, gate_sync_d;
  logic [SYNC_STAGES-1:0] prime_q, prime_d;
  logic                   sig_dly_q, sig_dly_d;
  logic                   gate_dly_q, gate_dly_d;
  logic                   armed_q, armed_d;
  logic [6:0][3:0]        num_q, num_d, num_inc;
  logic                   overflow_q, overflow_d;
  logic                   done_q, done_d;

  logic sig_s, gate_s, sig_rise, gate_rise, gate_fall, all_nines, carry;

  always_comb begin
    sig_sync_d  = {sig_sync_q[SYNC_STAGES-2:0], bus.sig_in};
    gate_sync_d = {gate_sync_q[SYNC_STAGES-2:0], bus.gate};
    prime_d     = {prime_q[SYNC_STAGES-2:0], 1'b1};
    sig_s       = sig_sync_q[SYNC_STAGES-1];
    gate_s      = gate_sync_q[SYNC_STAGES-1];
    sig_dly_d   = sig_s;
    gate_dly_d  = gate_s;
    sig_rise    = sig_s & ~sig_dly_q;
    gate_rise   = gate_s & ~gate_dly_q;
    gate_fall   = ~gate_s & gate_dly_q;
    // gate_s only reflects the pin once the synchronizer has refilled after
    // reset; a window may open only after a genuine low has been seen.
    armed_d     = armed_q | (prime_q[SYNC_STAGES-1] & ~gate_s);
  end

  always_comb begin
    num_inc   = num_q;
    carry     = 1'b1;
    all_nines = (num_q == {7{4'd9}});
    for (int unsigned i = 0; i < 7; i++) begin
      if (carry) begin
        if (num_q[i] >= 4'd9) begin
          num_inc[i] = '0;
        end else begin
          num_inc[i] = num_q[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (gate_rise && armed_q) state_d = CLEAR;
      end
      CLEAR: begin
        num_d      = '0;
        overflow_d = 1'b0;
        if (gate_fall) begin
          state_d = HOLD;
          done_d  = 1'b1;
        end else begin
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (gate_fall) begin
          state_d = HOLD;
          done_d  = 1'b1;
        end else if (sig_rise) begin
          if (all_nines) overflow_d = 1'b1;
          else           num_d      = num_inc;
        end
      end
      HOLD: begin
        if (gate_rise) state_d = CLEAR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sig_sync_q  <= '0;
      gate_sync_q <= '0;
      prime_q     <= '0;
      sig_dly_q   <= 1'b0;
      gate_dly_q  <= 1'b0;
      armed_q     <= 1'b0;
      num_q       <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sig_sync_q  <= sig_sync_d;
      gate_sync_q <= gate_sync_d;
      prime_q     <= prime_d;
      sig_dly_q   <= sig_dly_d;
      gate_dly_q  <= gate_dly_d;
      armed_q     <= armed_d;
      num_q       <= num_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
    end
  end

  assign bus.num0     = num_q[0];
  assign bus.num1     = num_q[1];
  assign bus.num2     = num_q[2];
  assign bus.num3     = num_q[3];
  assign bus.num4     = num_q[4];
  assign bus.num5     = num_q[5];
  assign bus.num6     = num_q[6];
  assign bus.overflow = overflow_q;
  assign bus.done     = done_q;
endmodule
